fp16_to_intn_quant: RTL and testbench

- Streaming quantizer: converts LANES packed fp16 values to signed INT_WIDTH-bit integers per beat.
- Inverse of the intN-to-fp16 expansion path. Sits at the output of the fp multiplier datapath and feeds narrow-integer consumers and writeback.
- 2-stage pipeline with valid/ready on both sides.
- Optional saturation-event counter for quantization diagnostics.

---
 rtl/fp16_to_intn_quant.sv | 251 +++++++++++++++++++++++++
 tb/tb_fp16_to_intn_quant.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_to_intn_quant.sv
`default_nettype none
// ============================================================================
// Module      : fp16_to_intn_quant
// Description : Streaming quantizer. Converts LANES packed IEEE binary16
//               values to signed INT_WIDTH-bit two's-complement integers
//               per beat. Round to nearest, ties to even, clamped to the
//               signed range. INT_WIDTH == 1 performs sign binarization.
//               Two-stage pipeline (decode, align/round/clamp) with
//               valid/ready handshaking on both sides.
// Optional    : `define FP2INT_SAT_CNT_EN enables the per-lane saturation
//               flags and the 32-bit saturation-event counter. Without it
//               sat_cnt_o is tied to zero and clear_cnt_i is ignored.
// Ports       : clk_i        clock, rising edge
//               rst_ni       asynchronous active-low reset
//               in_valid_i   input beat valid
//               in_ready_o   input beat accepted when valid & ready
//               in_data_i    lane k at [16k+15:16k], binary16
//               out_valid_o  output beat valid
//               out_ready_i  downstream accepts output beat
//               out_data_o   lane k at [W*k+W-1:W*k], two's complement
//               clear_cnt_i  synchronous clear of sat_cnt_o
//               sat_cnt_o    saturated lanes delivered (saturating count)
// Revision    : 1.0 - initial release
// ============================================================================
module fp16_to_intn_quant #(
    parameter int INT_WIDTH = 4,
    parameter int LANES     = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [16*LANES-1:0]        in_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [INT_WIDTH*LANES-1:0] out_data_o,
    input  logic                       clear_cnt_i,
    output logic [31:0]                sat_cnt_o
);

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic r_s1_valid;
    logic r_s2_valid;
    logic w_s1_ready;
    logic w_s2_ready;

    assign w_s2_ready  = ~r_s2_valid | out_ready_i;
    assign w_s1_ready  = ~r_s1_valid | w_s2_ready;
    assign in_ready_o  = w_s1_ready;
    assign out_valid_o = r_s2_valid;

    // ------------------------------------------------------------------
    // Stage 1: decode
    // ------------------------------------------------------------------
    logic [LANES-1:0]  w_dec_sign;
    logic [LANES-1:0]  w_dec_nan;
    logic [LANES-1:0]  w_dec_inf;
    logic signed [5:0] w_dec_exp [LANES];
    logic [10:0]       w_dec_sig [LANES];

    logic [LANES-1:0]  r_s1_sign;
    logic [LANES-1:0]  r_s1_nan;
    logic [LANES-1:0]  r_s1_inf;
    logic signed [5:0] r_s1_exp [LANES];
    logic [10:0]       r_s1_sig [LANES];

    for (genvar k = 0; k < LANES; k++) begin : g_dec
        logic [4:0] w_e;
        logic [9:0] w_m;
        assign w_e           = in_data_i[16*k+10 +: 5];
        assign w_m           = in_data_i[16*k    +: 10];
        assign w_dec_sign[k] = in_data_i[16*k+15];
        assign w_dec_nan[k]  = (w_e == 5'h1F) && (w_m != 10'd0);
        assign w_dec_inf[k]  = (w_e == 5'h1F) && (w_m == 10'd0);
        // Subnormals use the fixed exponent -14 with no hidden bit.
        assign w_dec_exp[k]  = (w_e == 5'd0) ? -6'sd14
                                             : $signed({1'b0, w_e}) - 6'sd15;
        assign w_dec_sig[k]  = {(w_e != 5'd0), w_m};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= '0;
            r_s1_nan   <= '0;
            r_s1_inf   <= '0;
            for (int i = 0; i < LANES; i++) begin
                r_s1_exp[i] <= '0;
                r_s1_sig[i] <= '0;
            end
        end else if (w_s1_ready) begin
            r_s1_valid <= in_valid_i;
            if (in_valid_i) begin
                r_s1_sign <= w_dec_sign;
                r_s1_nan  <= w_dec_nan;
                r_s1_inf  <= w_dec_inf;
                for (int i = 0; i < LANES; i++) begin
                    r_s1_exp[i] <= w_dec_exp[i];
                    r_s1_sig[i] <= w_dec_sig[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 combinational: align, round, clamp
    // ------------------------------------------------------------------
    logic [INT_WIDTH*LANES-1:0] w_s2_data;
    logic [LANES-1:0]           w_s2_sat;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        if (INT_WIDTH == 1) begin : g_bin
            logic w_unused_bin;
            assign w_s2_data[k] = ~r_s1_sign[k];
            assign w_s2_sat[k]  = 1'b0;
            assign w_unused_bin = ^{r_s1_nan[k], r_s1_inf[k],
                                    r_s1_exp[k], r_s1_sig[k]};
        end else begin : g_round
            localparam int c_ow = INT_WIDTH;
            localparam int c_iw = INT_WIDTH + 1;
            localparam logic signed [5:0]   c_w_s     = 6'(INT_WIDTH);
            localparam logic [INT_WIDTH:0]   c_pos_lim = c_iw'((1 << (INT_WIDTH - 1)) - 1);
            localparam logic [INT_WIDTH:0]   c_neg_lim = c_iw'(1 << (INT_WIDTH - 1));
            localparam logic [INT_WIDTH-1:0] c_max     = c_ow'((1 << (INT_WIDTH - 1)) - 1);
            localparam logic [INT_WIDTH-1:0] c_min     = c_ow'(1 << (INT_WIDTH - 1));

            logic [3:0]           w_shamt;
            logic [11:0]          w_ext;
            logic [11:0]          w_aligned;
            logic [11:0]          w_mask;
            logic                 w_guard;
            logic                 w_sticky;
            logic [INT_WIDTH:0]   w_int;
            logic [INT_WIDTH:0]   w_rnd;
            logic [INT_WIDTH-1:0] w_res;
            logic                 w_sat;

            // Value = sig * 2^(exp-10). Only exp in [-1, W-1] reaches the
            // aligner, so the shift stays within 3..11 and the integer part
            // fits W bits (one extra bit absorbs the rounding carry). The
            // bit just below the integer part is the guard; everything
            // below it folds into sticky.
            always_comb begin
                w_ext     = {r_s1_sig[k], 1'b0};
                w_shamt   = 4'(6'sd10 - r_s1_exp[k]);
                w_aligned = w_ext >> w_shamt;
                w_mask    = (12'd1 << w_shamt) - 12'd1;
                w_guard   = w_aligned[0];
                w_sticky  = |(w_ext & w_mask);
                w_int     = c_iw'(w_aligned >> 1);
                w_rnd     = w_int + c_iw'(w_guard & (w_sticky | w_int[0]));
                w_res     = '0;
                w_sat     = 1'b0;
                if (r_s1_nan[k]) begin
                    w_res = '0;
                end else if (r_s1_inf[k] || (r_s1_exp[k] >= c_w_s)) begin
                    // Magnitude >= 2^W: out of range without aligning.
                    w_sat = 1'b1;
                    w_res = r_s1_sign[k] ? c_min : c_max;
                end else if (r_s1_exp[k] < -6'sd1) begin
                    // Below 0.5, zero and subnormals.
                    w_res = '0;
                end else if (!r_s1_sign[k]) begin
                    if (w_rnd > c_pos_lim) begin
                        w_sat = 1'b1;
                        w_res = c_max;
                    end else begin
                        w_res = w_rnd[INT_WIDTH-1:0];
                    end
                end else begin
                    if (w_rnd > c_neg_lim) begin
                        w_sat = 1'b1;
                        w_res = c_min;
                    end else begin
                        w_res = c_ow'(-w_rnd);
                    end
                end
            end

            assign w_s2_data[k*INT_WIDTH +: INT_WIDTH] = w_res;
            assign w_s2_sat[k]                         = w_sat;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 registers
    // ------------------------------------------------------------------
    logic [INT_WIDTH*LANES-1:0] r_s2_data;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
        end else if (w_s2_ready) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data <= w_s2_data;
            end
        end
    end

    assign out_data_o = r_s2_data;

    // ------------------------------------------------------------------
    // Saturation-event counter
    // ------------------------------------------------------------------
`ifdef FP2INT_SAT_CNT_EN
    logic [LANES-1:0] r_s2_sat;
    logic [31:0]      r_sat_cnt;
    logic [31:0]      w_pop;
    logic [32:0]      w_sum;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s2_sat <= '0;
        end else if (w_s2_ready && r_s1_valid) begin
            r_s2_sat <= w_s2_sat;
        end
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < LANES; i++) begin
            w_pop = w_pop + 32'(r_s2_sat[i]);
        end
        w_sum = {1'b0, r_sat_cnt} + {1'b0, w_pop};
    end

    // Clear has priority over a coincident increment; the count sticks at
    // all-ones instead of wrapping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sat_cnt <= '0;
        end else if (clear_cnt_i) begin
            r_sat_cnt <= '0;
        end else if (r_s2_valid && out_ready_i) begin
            r_sat_cnt <= w_sum[32] ? 32'hFFFF_FFFF : w_sum[31:0];
        end
    end

    assign sat_cnt_o = r_sat_cnt;
`else
    logic w_unused_cnt;
    assign w_unused_cnt = ^{clear_cnt_i, w_s2_sat};
    assign sat_cnt_o    = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp16_to_intn_quant.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp16_to_intn_quant
// Description : Directed self-checking bench for fp16_to_intn_quant. Drives
//               an INT_WIDTH=4 and an INT_WIDTH=1 instance from the same
//               input stream and compares against hand-computed results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp16_to_intn_quant;

`ifdef FP2INT_SAT_CNT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        in_valid_i = 1'b0;
    logic [63:0] in_data_i = '0;
    logic        out_ready_i = 1'b1;
    logic        clear_cnt_i = 1'b0;

    logic        in_ready4, in_ready1;
    logic        out_valid4, out_valid1;
    logic [15:0] out_data4;
    logic [3:0]  out_data1;
    logic [31:0] sat_cnt4, sat_cnt1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    fp16_to_intn_quant #(.INT_WIDTH(4), .LANES(4)) dut4 (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready4),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid4),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data4),
        .clear_cnt_i (clear_cnt_i),
        .sat_cnt_o   (sat_cnt4)
    );

    fp16_to_intn_quant #(.INT_WIDTH(1), .LANES(4)) dut1 (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready1),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid1),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data1),
        .clear_cnt_i (clear_cnt_i),
        .sat_cnt_o   (sat_cnt1)
    );

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge. Presents one beat, waits for acceptance,
    // measures handshake-to-valid latency and checks both outputs. Returns
    // 1 ns after the falling edge where the output is valid; out_ready_i is
    // high so the output handshake happens at the next rising edge.
    task automatic send_and_check(input string tag, input logic [63:0] d,
                                  input logic [15:0] e4, input logic [3:0] e1);
        int k;
        int lat;
        in_valid_i = 1'b1;
        in_data_i  = d;
        #1;
        k = 0;
        while (!in_ready4 && k < 10) begin
            @(negedge clk_i);
            #1;
            k++;
        end
        @(negedge clk_i);
        in_valid_i = 1'b0;
        lat = 1;
        #1;
        while (!out_valid4 && lat < 10) begin
            @(negedge clk_i);
            #1;
            lat++;
        end
        check_value({tag, "_lat"}, 32'(lat), 32'd2);
        check_value({tag, "_d4"}, 32'(out_data4), 32'(e4));
        check_value({tag, "_v1"}, 32'(out_valid1), 32'd1);
        check_value({tag, "_d1"}, 32'(out_data1), 32'(e1));
    endtask

    task automatic check_cnt(input string tag, input logic [31:0] exp);
        check_value({tag, "_cnt4"}, sat_cnt4, SAT_EN ? exp : 32'd0);
        check_value({tag, "_cnt1"}, sat_cnt1, 32'd0);
    endtask

    logic [63:0] bp_d  [6];
    logic [15:0] bp_e4 [6];
    logic [3:0]  bp_e1 [6];

    initial begin
        int sent;
        int rcv;
        logic saw_drop;

        // Vectors: lane 0 in the low 16 bits.
        bp_d[0] = 64'h3E00_3800_4300_4100; bp_e4[0] = 16'h2042; bp_e1[0] = 4'b1111;
        bp_d[1] = 64'h7E00_C880_C800_4800; bp_e4[1] = 16'h0887; bp_e1[1] = 4'b1001;
        bp_d[2] = 64'h0001_8000_FC00_7C00; bp_e4[2] = 16'h0087; bp_e1[2] = 4'b1001;
        bp_d[3] = 64'h5000_4780_C780_4700; bp_e4[3] = 16'h7787; bp_e1[3] = 4'b1101;
        bp_d[4] = 64'h8000_0000_BC00_3C00; bp_e4[4] = 16'h00F1; bp_e1[4] = 4'b0101;
        bp_d[5] = 64'h3A00_3C01_C100_4000; bp_e4[5] = 16'h11E2; bp_e1[5] = 4'b1101;

        // Reset state
        repeat (3) @(negedge clk_i);
        #1;
        check_value("rst_valid", 32'(out_valid4), 32'd0);
        check_value("rst_data", 32'(out_data4), 32'd0);
        check_value("rst_cnt", sat_cnt4, 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        #1;
        check_value("rst_ready", 32'(in_ready4), 32'd1);
        @(negedge clk_i);

        // Rounding: 2.5, 3.5, 0.5, 1.5
        send_and_check("round", bp_d[0], bp_e4[0], bp_e1[0]);
        @(negedge clk_i); #1;
        check_cnt("round", 32'd0);
        @(negedge clk_i);

        // Clamp: 8.0, -8.0, -9.0, NaN
        send_and_check("clamp", bp_d[1], bp_e4[1], bp_e1[1]);
        @(negedge clk_i); #1;
        check_cnt("clamp", 32'd2);
        @(negedge clk_i);

        // Specials: +inf, -inf, -0, subnormal
        send_and_check("spec", bp_d[2], bp_e4[2], bp_e1[2]);
        @(negedge clk_i); #1;
        check_cnt("spec", 32'd4);
        @(negedge clk_i);

        // Same beat with clear asserted on the output handshake
        send_and_check("clr", bp_d[2], bp_e4[2], bp_e1[2]);
        clear_cnt_i = 1'b1;
        @(negedge clk_i);
        clear_cnt_i = 1'b0;
        #1;
        check_cnt("clr", 32'd0);
        @(negedge clk_i);

        // Range edges: 7.0, -7.5 -> -8 (in range), 7.5 -> 8 (sat), 32.0
        send_and_check("edge", bp_d[3], bp_e4[3], bp_e1[3]);
        @(negedge clk_i); #1;
        check_cnt("edge", 32'd2);
        @(negedge clk_i);

        // Binarization vector: 1.0, -1.0, +0, -0
        send_and_check("bin", bp_d[4], bp_e4[4], bp_e1[4]);
        @(negedge clk_i); #1;
        check_cnt("bin", 32'd2);
        @(negedge clk_i);

        // Sticky and guard: 2.0, -2.5, 1+2^-10, 0.75
        send_and_check("stky", bp_d[5], bp_e4[5], bp_e1[5]);
        @(negedge clk_i); #1;
        check_cnt("stky", 32'd2);
        @(negedge clk_i);

        // Backpressure: six beats back-to-back, downstream stalls 3 cycles
        sent = 0;
        rcv = 0;
        saw_drop = 1'b0;
        for (int c = 0; c < 40 && rcv < 6; c++) begin
            out_ready_i = !(c >= 2 && c < 5);
            in_valid_i  = (sent < 6);
            in_data_i   = (sent < 6) ? bp_d[sent] : 64'd0;
            #1;
            if (!in_ready4) saw_drop = 1'b1;
            if (out_valid4 && rcv < 6) begin
                check_value("bp_d4", 32'(out_data4), 32'(bp_e4[rcv]));
                check_value("bp_d1", 32'(out_data1), 32'(bp_e1[rcv]));
                if (out_ready_i) rcv++;
            end
            if (in_valid_i && in_ready4) sent++;
            @(negedge clk_i);
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        #1;
        check_value("bp_rcv", 32'(rcv), 32'd6);
        check_value("bp_sent", 32'(sent), 32'd6);
        check_value("bp_drop", 32'(saw_drop), 32'd1);
        check_value("bp_drain", 32'(out_valid4), 32'd0);
        check_cnt("bp", 32'd8);
        @(negedge clk_i);

        // Reset with two beats in flight
        in_valid_i = 1'b1;
        in_data_i  = bp_d[0];
        @(negedge clk_i);
        in_data_i  = bp_d[1];
        @(negedge clk_i);
        in_valid_i = 1'b0;
        #1;
        check_value("mid_pre", 32'(out_valid4), 32'd1);
        rst_ni = 1'b0;
        #1;
        check_value("mid_valid", 32'(out_valid4), 32'd0);
        check_value("mid_data", 32'(out_data4), 32'd0);
        check_value("mid_cnt", sat_cnt4, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        #1;
        check_value("mid_drain", 32'(out_valid4), 32'd0);
        @(negedge clk_i);
        send_and_check("post", bp_d[2], bp_e4[2], bp_e1[2]);
        @(negedge clk_i); #1;
        check_cnt("post", 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
